// File: rtl/terminate_station.sv
// terminate_station: reservation station for terminate ops.
//
// Holds up to DEPTH dispatched ops until their base and flags operands are
// available, snoops the common result bus for missing operands, and hands the
// oldest ready op to terminate_pipeline through a registered valid/ready port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous discard of all entries and the output register
//   in_valid/in_ready   dispatch handshake; in_ready depends on registered state only
//   in_opcode/offset/immediate  static op fields, stored verbatim
//   in_base_*           base-address operand (ready, tag, 16-bit value)
//   in_flags_*          flags operand (ready, tag, 8-bit value)
//   cdb_valid/tag/data  common result broadcast
//   out_valid/out_ready registered issue handshake to terminate_pipeline
//   out_*               registered operands of the issued op
module terminate_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [7:0]       in_offset,
  input  logic [3:0]       in_immediate,
  input  logic             in_base_ready,
  input  logic [TAG_W-1:0] in_base_tag,
  input  logic [15:0]      in_base_val,
  input  logic             in_flags_ready,
  input  logic [TAG_W-1:0] in_flags_tag,
  input  logic [7:0]       in_flags_val,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [15:0]      cdb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_opcode,
  output logic [15:0]      out_reg_base_val,
  output logic [7:0]       out_flag_vals,
  output logic [7:0]       out_offset,
  output logic [3:0]       out_immediate
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] OP_UNCOND = 4'b1111;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [7:0]       offset;
    logic [3:0]       immediate;
    logic             base_rdy;
    logic [TAG_W-1:0] base_tag;
    logic [15:0]      base_val;
    logic             flags_rdy;
    logic [TAG_W-1:0] flags_tag;
    logic [7:0]       flags_val;
  } entry_t;

  logic [DEPTH-1:0]            vld_q, vld_d;
  entry_t [DEPTH-1:0]          ent_q, ent_d;
  // age_q[i][j] set means entry i was accepted before entry j; a matrix has no
  // wrap hazard however long an old entry waits behind younger traffic.
  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_opcode_q, out_opcode_d;
  logic [15:0] out_base_q, out_base_d;
  logic [7:0]  out_flags_q, out_flags_d;
  logic [7:0]  out_offset_q, out_offset_d;
  logic [3:0]  out_imm_q, out_imm_d;

  logic [DEPTH-1:0] elig_s, pick_s;
  logic [IDX_W-1:0] issue_idx_s, free_idx_s;
  logic             issue_s, accept_s;
  entry_t           new_ent_s;

  assign in_ready = ~&vld_q;
  assign accept_s = in_valid && in_ready && !flush;
  assign issue_s  = (|pick_s) && (!out_valid_q || out_ready);

  // Eligibility looks only at registered readiness, so a CDB capture issues one cycle later.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      elig_s[i] = vld_q[i] && ent_q[i].base_rdy &&
                  (ent_q[i].flags_rdy || (ent_q[i].opcode == OP_UNCOND));
    end
  end

  // An eligible entry is picked when no other eligible entry is older than it.
  always_comb begin
    logic blocked;
    pick_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (elig_s[j] && age_q[j][i]) begin
          blocked = 1'b1;
        end else begin
          blocked = blocked;
        end
      end
      pick_s[i] = elig_s[i] && !blocked;
    end
  end

  // Encode the picked entry and the lowest-index free slot.
  always_comb begin
    issue_idx_s = '0;
    free_idx_s  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pick_s[i]) begin
        issue_idx_s = IDX_W'(i);
      end else begin
        issue_idx_s = issue_idx_s;
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        free_idx_s = IDX_W'(i);
      end else begin
        free_idx_s = free_idx_s;
      end
    end
  end

  // Build the incoming entry, taking a same-cycle broadcast for a missing operand.
  always_comb begin
    new_ent_s           = '0;
    new_ent_s.opcode    = in_opcode;
    new_ent_s.offset    = in_offset;
    new_ent_s.immediate = in_immediate;
    new_ent_s.base_tag  = in_base_tag;
    new_ent_s.flags_tag = in_flags_tag;
    if (!in_base_ready && cdb_valid && (cdb_tag == in_base_tag)) begin
      new_ent_s.base_rdy = 1'b1;
      new_ent_s.base_val = cdb_data;
    end else begin
      new_ent_s.base_rdy = in_base_ready;
      new_ent_s.base_val = in_base_val;
    end
    if (!in_flags_ready && cdb_valid && (cdb_tag == in_flags_tag)) begin
      new_ent_s.flags_rdy = 1'b1;
      new_ent_s.flags_val = cdb_data[7:0];
    end else begin
      new_ent_s.flags_rdy = in_flags_ready;
      new_ent_s.flags_val = in_flags_val;
    end
  end

  // Next state: flush overrides issue, CDB capture and dispatch.
  always_comb begin
    vld_d        = vld_q;
    ent_d        = ent_q;
    age_d        = age_q;
    out_valid_d  = out_valid_q;
    out_opcode_d = out_opcode_q;
    out_base_d   = out_base_q;
    out_flags_d  = out_flags_q;
    out_offset_d = out_offset_q;
    out_imm_d    = out_imm_q;
    if (flush) begin
      vld_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (issue_s) begin
        vld_d[issue_idx_s] = 1'b0;
        out_valid_d        = 1'b1;
        out_opcode_d       = ent_q[issue_idx_s].opcode;
        out_base_d         = ent_q[issue_idx_s].base_val;
        out_flags_d        = ent_q[issue_idx_s].flags_val;
        out_offset_d       = ent_q[issue_idx_s].offset;
        out_imm_d          = ent_q[issue_idx_s].immediate;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && vld_q[i]) begin
          if (!ent_q[i].base_rdy && (ent_q[i].base_tag == cdb_tag)) begin
            ent_d[i].base_rdy = 1'b1;
            ent_d[i].base_val = cdb_data;
          end else begin
            ent_d[i].base_rdy = ent_q[i].base_rdy;
          end
          if (!ent_q[i].flags_rdy && (ent_q[i].flags_tag == cdb_tag)) begin
            ent_d[i].flags_rdy = 1'b1;
            ent_d[i].flags_val = cdb_data[7:0];
          end else begin
            ent_d[i].flags_rdy = ent_q[i].flags_rdy;
          end
        end else begin
          ent_d[i] = ent_q[i];
        end
      end
      if (accept_s) begin
        vld_d[free_idx_s] = 1'b1;
        ent_d[free_idx_s] = new_ent_s;
        // The newcomer is younger than every other slot.
        age_d[free_idx_s] = '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != int'(free_idx_s)) begin
            age_d[j][free_idx_s] = 1'b1;
          end else begin
            age_d[j][free_idx_s] = 1'b0;
          end
        end
      end else begin
        age_d = age_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= '0;
      ent_q        <= '0;
      age_q        <= '0;
      out_valid_q  <= 1'b0;
      out_opcode_q <= 4'h0;
      out_base_q   <= 16'h0000;
      out_flags_q  <= 8'h00;
      out_offset_q <= 8'h00;
      out_imm_q    <= 4'h0;
    end else begin
      vld_q        <= vld_d;
      ent_q        <= ent_d;
      age_q        <= age_d;
      out_valid_q  <= out_valid_d;
      out_opcode_q <= out_opcode_d;
      out_base_q   <= out_base_d;
      out_flags_q  <= out_flags_d;
      out_offset_q <= out_offset_d;
      out_imm_q    <= out_imm_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_opcode       = out_opcode_q;
  assign out_reg_base_val = out_base_q;
  assign out_flag_vals    = out_flags_q;
  assign out_offset       = out_offset_q;
  assign out_immediate    = out_imm_q;

endmodule

// File: tb/tb_terminate_station.sv
module tb_terminate_station;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic             clk, rst, flush, in_valid, in_ready;
  logic [3:0]       in_opcode, in_immediate;
  logic [7:0]       in_offset;
  logic             in_base_ready, in_flags_ready;
  logic [TAG_W-1:0] in_base_tag, in_flags_tag, cdb_tag;
  logic [15:0]      in_base_val, cdb_data;
  logic [7:0]       in_flags_val;
  logic             cdb_valid, out_valid, out_ready;
  logic [3:0]       out_opcode, out_immediate;
  logic [15:0]      out_reg_base_val;
  logic [7:0]       out_flag_vals, out_offset;

  terminate_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_offset(in_offset), .in_immediate(in_immediate),
    .in_base_ready(in_base_ready), .in_base_tag(in_base_tag), .in_base_val(in_base_val),
    .in_flags_ready(in_flags_ready), .in_flags_tag(in_flags_tag), .in_flags_val(in_flags_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_reg_base_val(out_reg_base_val),
    .out_flag_vals(out_flag_vals), .out_offset(out_offset), .out_immediate(out_immediate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: waiting ops kept in acceptance order.
  typedef struct {
    logic [3:0] op; logic [7:0] off; logic [3:0] imm;
    logic br; logic [5:0] bt; logic [15:0] bv;
    logic fr; logic [5:0] ft; logic [7:0] fv;
  } ent_t;

  typedef struct {
    logic iv; logic [3:0] op; logic [7:0] off; logic [3:0] imm;
    logic br; logic [5:0] bt; logic [15:0] bv;
    logic fr; logic [5:0] ft; logic [7:0] fv;
    logic cv; logic [5:0] ct; logic [15:0] cd;
  } in_t;

  typedef struct {
    logic ov; logic [3:0] op; logic [15:0] base; logic cf; logic [7:0] flags; logic [7:0] off; logic [3:0] imm;
  } exp_t;

  typedef struct { in_t i; exp_t e; } vec_t;

  ent_t mq[$];
  logic m_ov;
  ent_t m_out;
  int   tests = 0;
  int   fails = 0;
  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    ent_t e;
    int   cnt;
    int   sel;
    if (flush) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
      cnt = mq.size();
      sel = -1;
      if (!m_ov || out_ready) begin
        foreach (mq[i]) if (sel < 0 && mq[i].br && (mq[i].fr || mq[i].op == 4'hF)) sel = i;
      end
      if (sel >= 0) begin
        m_out = mq[sel];
        m_ov  = 1'b1;
        mq.delete(sel);
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (cdb_valid) begin
        foreach (mq[i]) begin
          if (!mq[i].br && mq[i].bt == cdb_tag) begin mq[i].br = 1'b1; mq[i].bv = cdb_data; end
          if (!mq[i].fr && mq[i].ft == cdb_tag) begin mq[i].fr = 1'b1; mq[i].fv = cdb_data[7:0]; end
        end
      end
      if (in_valid && cnt < DEPTH) begin
        e = '{in_opcode, in_offset, in_immediate, in_base_ready, in_base_tag, in_base_val,
              in_flags_ready, in_flags_tag, in_flags_val};
        if (!e.br && cdb_valid && e.bt == cdb_tag) begin e.br = 1'b1; e.bv = cdb_data; end
        if (!e.fr && cdb_valid && e.ft == cdb_tag) begin e.fr = 1'b1; e.fv = cdb_data[7:0]; end
        mq.push_back(e);
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("model_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("model_out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("model_opcode", 32'(out_opcode), 32'(m_out.op));
      chk("model_base", 32'(out_reg_base_val), 32'(m_out.bv));
      chk("model_offset", 32'(out_offset), 32'(m_out.off));
      chk("model_imm", 32'(out_immediate), 32'(m_out.imm));
      if (m_out.fr) chk("model_flags", 32'(out_flag_vals), 32'(m_out.fv));
    end
  endtask

  function automatic in_t dsp(input logic [3:0] op, input logic [7:0] off, input logic [3:0] imm,
                              input logic br, input logic [5:0] bt, input logic [15:0] bv,
                              input logic fr, input logic [5:0] ft, input logic [7:0] fv);
    in_t t;
    t = '{1'b1, op, off, imm, br, bt, bv, fr, ft, fv, 1'b0, 6'd0, 16'h0000};
    return t;
  endfunction

  function automatic in_t idle_in(input logic cv, input logic [5:0] ct, input logic [15:0] cd);
    in_t t;
    t = '{1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 8'h00, cv, ct, cd};
    return t;
  endfunction

  function automatic exp_t eo(input logic [3:0] op, input logic [15:0] base, input logic cf,
                              input logic [7:0] flags, input logic [7:0] off, input logic [3:0] imm);
    exp_t x;
    x = '{1'b1, op, base, cf, flags, off, imm};
    return x;
  endfunction

  function automatic exp_t none();
    exp_t x;
    x = '{1'b0, 4'h0, 16'h0000, 1'b0, 8'h00, 8'h00, 4'h0};
    return x;
  endfunction

  task automatic drive_op(input logic [3:0] op, input logic [7:0] off, input logic [3:0] imm,
                          input logic br, input logic [5:0] bt, input logic [15:0] bv,
                          input logic fr, input logic [5:0] ft, input logic [7:0] fv);
    in_valid = 1'b1; in_opcode = op; in_offset = off; in_immediate = imm;
    in_base_ready = br; in_base_tag = bt; in_base_val = bv;
    in_flags_ready = fr; in_flags_tag = ft; in_flags_val = fv;
    cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic apply_vec(input vec_t t, input int r);
    in_valid = t.i.iv; in_opcode = t.i.op; in_offset = t.i.off; in_immediate = t.i.imm;
    in_base_ready = t.i.br; in_base_tag = t.i.bt; in_base_val = t.i.bv;
    in_flags_ready = t.i.fr; in_flags_tag = t.i.ft; in_flags_val = t.i.fv;
    cdb_valid = t.i.cv; cdb_tag = t.i.ct; cdb_data = t.i.cd;
    flush = 1'b0; out_ready = 1'b1;
    step();
    chk($sformatf("tbl%0d_in_ready", r), 32'(in_ready), 32'd1);
    chk($sformatf("tbl%0d_out_valid", r), 32'(out_valid), 32'(t.e.ov));
    if (t.e.ov) begin
      chk($sformatf("tbl%0d_opcode", r), 32'(out_opcode), 32'(t.e.op));
      chk($sformatf("tbl%0d_base", r), 32'(out_reg_base_val), 32'(t.e.base));
      chk($sformatf("tbl%0d_offset", r), 32'(out_offset), 32'(t.e.off));
      chk($sformatf("tbl%0d_imm", r), 32'(out_immediate), 32'(t.e.imm));
      if (t.e.cf) chk($sformatf("tbl%0d_flags", r), 32'(out_flag_vals), 32'(t.e.flags));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Unconditional op with only the base ready issues one edge after dispatch.
    tbl[0]  = '{dsp(4'hF, 8'h00, 4'h1, 1'b1, 6'd0, 16'h0008, 1'b0, 6'd0, 8'h00), none()};
    tbl[1]  = '{idle_in(1'b0, 6'd0, 16'h0000), eo(4'hF, 16'h0008, 1'b0, 8'h00, 8'h00, 4'h1)};
    tbl[2]  = '{idle_in(1'b0, 6'd0, 16'h0000), none()};
    // Flags wait for tag 5, then issue one edge after the capture.
    tbl[3]  = '{dsp(4'hE, 8'h02, 4'hC, 1'b1, 6'd0, 16'h0009, 1'b0, 6'd5, 8'h00), none()};
    tbl[4]  = '{idle_in(1'b0, 6'd0, 16'h0000), none()};
    tbl[5]  = '{idle_in(1'b1, 6'd5, 16'h00F7), none()};
    tbl[6]  = '{idle_in(1'b0, 6'd0, 16'h0000), eo(4'hE, 16'h0009, 1'b1, 8'hF7, 8'h02, 4'hC)};
    tbl[7]  = '{idle_in(1'b0, 6'd0, 16'h0000), none()};
    // Same-cycle broadcast bypass at dispatch.
    tbl[8]  = '{dsp(4'h3, 8'h11, 4'h2, 1'b1, 6'd0, 16'h0100, 1'b0, 6'd7, 8'h00), none()};
    tbl[8].i.cv = 1'b1; tbl[8].i.ct = 6'd7; tbl[8].i.cd = 16'h0001;
    tbl[9]  = '{idle_in(1'b0, 6'd0, 16'h0000), eo(4'h3, 16'h0100, 1'b1, 8'h01, 8'h11, 4'h2)};
    tbl[10] = '{idle_in(1'b0, 6'd0, 16'h0000), none()};
    // A waits on tag 3, younger B is ready and overtakes it.
    tbl[11] = '{dsp(4'h1, 8'hA1, 4'h1, 1'b1, 6'd0, 16'h0A0A, 1'b0, 6'd3, 8'h00), none()};
    tbl[12] = '{dsp(4'h2, 8'hB2, 4'h2, 1'b1, 6'd0, 16'h0B0B, 1'b1, 6'd0, 8'hBB), none()};
    tbl[13] = '{idle_in(1'b1, 6'd3, 16'h00AA), eo(4'h2, 16'h0B0B, 1'b1, 8'hBB, 8'hB2, 4'h2)};
    tbl[14] = '{idle_in(1'b0, 6'd0, 16'h0000), eo(4'h1, 16'h0A0A, 1'b1, 8'hAA, 8'hA1, 4'h1)};
    tbl[15] = '{idle_in(1'b0, 6'd0, 16'h0000), none()};
    // C and D become ready together; the older one goes first.
    tbl[16] = '{dsp(4'h4, 8'hC4, 4'h4, 1'b1, 6'd0, 16'h0C0C, 1'b0, 6'd9, 8'h00), none()};
    tbl[17] = '{dsp(4'h5, 8'hD5, 4'h5, 1'b1, 6'd0, 16'h0D0D, 1'b0, 6'd9, 8'h00), none()};
    tbl[18] = '{idle_in(1'b1, 6'd9, 16'h0033), none()};
    tbl[19] = '{idle_in(1'b0, 6'd0, 16'h0000), eo(4'h4, 16'h0C0C, 1'b1, 8'h33, 8'hC4, 4'h4)};
    tbl[20] = '{idle_in(1'b0, 6'd0, 16'h0000), eo(4'h5, 16'h0D0D, 1'b1, 8'h33, 8'hD5, 4'h5)};
    tbl[21] = '{idle_in(1'b0, 6'd0, 16'h0000), none()};

    rst = 1'b1; out_ready = 1'b0; m_ov = 1'b0;
    drive_op(4'h0, 8'h00, 4'h0, 1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 8'h00);
    drive_idle(); cdb_tag = 6'd0; cdb_data = 16'h0000;
    #12;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_base", 32'(out_reg_base_val), 32'd0);
    chk("reset_flags", 32'(out_flag_vals), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int r = 0; r < 22; r++) apply_vec(tbl[r], r);

    // Fill all slots, then hold the presented op with out_ready low.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_op(4'h6, 8'(k), 4'(k), 1'b1, 6'd0, 16'h1000 + 16'(k), 1'b0, 6'd20, 8'h00);
      step();
    end
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    drive_idle(); cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_data = 16'h0055;
    step();
    drive_idle();
    step();
    chk("fill_first_ov", 32'(out_valid), 32'd1);
    chk("fill_first_off", 32'(out_offset), 32'd0);
    chk("freed_in_ready", 32'(in_ready), 32'd1);
    drive_op(4'h6, 8'h09, 4'h9, 1'b1, 6'd0, 16'h2000, 1'b1, 6'd0, 8'h99);
    step();
    chk("refill_in_ready", 32'(in_ready), 32'd0);
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_ov", 32'(out_valid), 32'd1);
      chk("hold_base", 32'(out_reg_base_val), 32'h1000);
      chk("hold_flags", 32'(out_flag_vals), 32'h55);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("ready_no_comb", 32'(in_ready), 32'd0);
    step();
    chk("release_off", 32'(out_offset), 32'h01);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 5; k++) step();

    // Flush with three resident ops and a presented op.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_op(4'h7, 8'h30 + 8'(k), 4'h7, 1'b1, 6'd0, 16'h3000 + 16'(k), 1'b1, 6'd0, 8'h77);
      step();
    end
    chk("pre_flush_ov", 32'(out_valid), 32'd1);
    drive_op(4'h8, 8'h80, 4'h8, 1'b1, 6'd0, 16'h8000, 1'b1, 6'd0, 8'h88);
    flush = 1'b1; out_ready = 1'b1; cdb_valid = 1'b1; cdb_tag = 6'd1; cdb_data = 16'h1111;
    step();
    chk("flush_ov", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_flush_ov", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset in the middle of a cycle with an op presented.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_op(4'h9, 8'h42, 4'h4, 1'b1, 6'd0, 16'h4242, 1'b1, 6'd0, 8'h24);
      step();
    end
    chk("pre_rst_ov", 32'(out_valid), 32'd1);
    drive_idle();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_base", 32'(out_reg_base_val), 32'd0);
    chk("rst_offset", 32'(out_offset), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    mq.delete(); m_ov = 1'b0;
    @(posedge clk); #1;
    chk("rst_hold_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_ov", 32'(out_valid), 32'd0);
    end

    // Randomized traffic against the model; small tag space forces CDB hits.
    for (int n = 0; n < 3000; n++) begin
      in_valid       = 1'($urandom_range(0, 1));
      in_opcode      = 4'($urandom);
      in_offset      = 8'($urandom);
      in_immediate   = 4'($urandom);
      in_base_ready  = ($urandom_range(0, 2) != 0);
      in_base_tag    = 6'($urandom_range(0, 7));
      in_base_val    = 16'($urandom);
      in_flags_ready = ($urandom_range(0, 2) != 0);
      in_flags_tag   = 6'($urandom_range(0, 7));
      in_flags_val   = 8'($urandom);
      cdb_valid      = 1'($urandom_range(0, 1));
      cdb_tag        = 6'($urandom_range(0, 7));
      cdb_data       = 16'($urandom);
      out_ready      = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
